ctrl_pipe_hazard: RTL and testbench

//  Consumes the decode-stage control word from the controller. Carries it through the E/M/W

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/ctrl_pipe_hazard_pipe_reg.sv | 41 ++++
 rtl/ctrl_pipe_hazard.sv | 248 ++++++++++++++++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings and the E-stage control word for the control
// pipeline / hazard unit of the 5-stage RV32I core.
// Optional feature macro used by the importing files: CTRL_FORWARD_EN.
package ctrl_pkg;

    // ResultSrc: selects what the W stage writes back
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_IMM  = 2'b11;

    // ALU operand forward selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int ALUCTRL_W = 3;

    // Control word carried from D into E
    typedef struct packed {
        logic [1:0]           result_src;
        logic [ALUCTRL_W-1:0] alu_control;
        logic                 mem_write;
        logic                 alu_src;
        logic                 reg_write;
        logic                 branch;
        logic                 jump;
        logic                 sel_adder;
    } ctrl_e_t;

    localparam int CTRL_E_W = $bits(ctrl_e_t);

endpackage

// File: rtl/ctrl_pipe_hazard_pipe_reg.sv
// pipe_reg_ctrl: W-bit pipeline register with synchronous reset, load enable
// and synchronous clear. Clear wins over enable so a flushed stage always
// becomes a NOP even when the stage would otherwise load.
module pipe_reg_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Next-state selection: clear, load or hold
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (en) begin
            data_d = d;
        end else begin
            data_d = data_q;
        end
    end

    // Stage storage with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: carries the decode control word through E/M/W, detects
// load-use / RAW / control hazards, drives stall, flush, redirect and operand
// forward selects, and counts stall and flush cycles (saturating).
// Macro CTRL_FORWARD_EN: when defined, E-stage operands are forwarded from M/W;
// when undefined, forwards are tied to the register file and every RAW hazard
// on an in-flight writer in E or M stalls decode instead.
module ctrl_pipe_hazard
    import ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           ResultSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic                 MemWriteD,
    input  logic                 ALUSrcD,
    input  logic                 RegWriteD,
    input  logic                 BranchD,
    input  logic                 JumpD,
    input  logic                 sel_adder,
    input  logic [REG_W-1:0]     Rs1D,
    input  logic [REG_W-1:0]     Rs2D,
    input  logic [REG_W-1:0]     RdD,
    input  logic                 BranchCondE,
    output logic [1:0]           ResultSrcE,
    output logic [1:0]           ResultSrcM,
    output logic [1:0]           ResultSrcW,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 sel_adderE,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic [REG_W-1:0]     Rs1E,
    output logic [REG_W-1:0]     Rs2E,
    output logic [REG_W-1:0]     RdE,
    output logic [REG_W-1:0]     RdM,
    output logic [REG_W-1:0]     RdW,
    output logic                 PCSrcE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int DE_W = CTRL_E_W + 3 * REG_W;
    localparam int EM_W = 4 + REG_W;
    localparam int MW_W = 3 + REG_W;

    // True when a non-x0 destination is read by either source index
    function automatic logic src_hit(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs1,
                                     input logic [REG_W-1:0] rs2);
        return (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

    // Increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    ctrl_e_t          ctrl_d_s;
    ctrl_e_t          ctrl_e_s;
    logic [DE_W-1:0]  de_d_s;
    logic [DE_W-1:0]  de_q_s;
    logic [EM_W-1:0]  em_d_s;
    logic [EM_W-1:0]  em_q_s;
    logic [MW_W-1:0]  mw_q_s;
    logic [REG_W-1:0] rs1_e_s;
    logic [REG_W-1:0] rs2_e_s;
    logic [REG_W-1:0] rd_e_s;
    logic [1:0]       res_m_s;
    logic             memw_m_s;
    logic             regw_m_s;
    logic [REG_W-1:0] rd_m_s;
    logic [1:0]       res_w_s;
    logic             regw_w_s;
    logic [REG_W-1:0] rd_w_s;

    logic             lw_stall_s;
    logic             stall_src_s;
    logic             pcsrc_s;
    logic             stall_s;
    logic             flush_e_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;

    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;

    // Pack the decode control word and register indices for the D->E stage
    always_comb begin
        ctrl_d_s             = '0;
        ctrl_d_s.result_src  = ResultSrcD;
        ctrl_d_s.alu_control = ALUControlD;
        ctrl_d_s.mem_write   = MemWriteD;
        ctrl_d_s.alu_src     = ALUSrcD;
        ctrl_d_s.reg_write   = RegWriteD;
        ctrl_d_s.branch      = BranchD;
        ctrl_d_s.jump        = JumpD;
        ctrl_d_s.sel_adder   = sel_adder;
        de_d_s               = {ctrl_d_s, Rs1D, Rs2D, RdD};
    end

    pipe_reg_ctrl #(.W(DE_W)) u_de (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (flush_e_s),
        .d   (de_d_s),
        .q   (de_q_s)
    );

    assign ctrl_e_s = de_q_s[DE_W-1 -: CTRL_E_W];
    assign rs1_e_s  = de_q_s[3*REG_W-1 -: REG_W];
    assign rs2_e_s  = de_q_s[2*REG_W-1 -: REG_W];
    assign rd_e_s   = de_q_s[REG_W-1:0];
    assign em_d_s   = {ctrl_e_s.result_src, ctrl_e_s.mem_write, ctrl_e_s.reg_write, rd_e_s};

    pipe_reg_ctrl #(.W(EM_W)) u_em (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (1'b0),
        .d   (em_d_s),
        .q   (em_q_s)
    );

    assign {res_m_s, memw_m_s, regw_m_s, rd_m_s} = em_q_s;

    pipe_reg_ctrl #(.W(MW_W)) u_mw (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (1'b0),
        .d   ({res_m_s, regw_m_s, rd_m_s}),
        .q   (mw_q_s)
    );

    assign {res_w_s, regw_w_s, rd_w_s} = mw_q_s;

    // Hazard detection; a redirect squashes the stalled instruction so it wins
    always_comb begin
        lw_stall_s  = 1'b0;
        stall_src_s = 1'b0;
        if ((ctrl_e_s.result_src == RES_LOAD) && src_hit(rd_e_s, Rs1D, Rs2D)) begin
            lw_stall_s = 1'b1;
        end else begin
            lw_stall_s = 1'b0;
        end
`ifdef CTRL_FORWARD_EN
        stall_src_s = lw_stall_s;
`else
        stall_src_s = lw_stall_s
                    | (ctrl_e_s.reg_write & src_hit(rd_e_s, Rs1D, Rs2D))
                    | (regw_m_s & src_hit(rd_m_s, Rs1D, Rs2D));
`endif
        pcsrc_s   = ctrl_e_s.jump | (ctrl_e_s.branch & BranchCondE);
        flush_e_s = stall_src_s | pcsrc_s;
        stall_s   = stall_src_s & ~pcsrc_s;
    end

    // Operand forward selects; M is younger than W so it takes priority
    always_comb begin
        fwd_a_s = FWD_RF;
        fwd_b_s = FWD_RF;
`ifdef CTRL_FORWARD_EN
        if (regw_m_s && (rd_m_s != '0) && (rd_m_s == rs1_e_s)) begin
            fwd_a_s = FWD_M;
        end else if (regw_w_s && (rd_w_s != '0) && (rd_w_s == rs1_e_s)) begin
            fwd_a_s = FWD_W;
        end else begin
            fwd_a_s = FWD_RF;
        end
        if (regw_m_s && (rd_m_s != '0) && (rd_m_s == rs2_e_s)) begin
            fwd_b_s = FWD_M;
        end else if (regw_w_s && (rd_w_s != '0) && (rd_w_s == rs2_e_s)) begin
            fwd_b_s = FWD_W;
        end else begin
            fwd_b_s = FWD_RF;
        end
`endif
    end

    // Next values of the saturating stall/flush counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_e_s) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers, cleared together with the pipe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ResultSrcE  = ctrl_e_s.result_src;
    assign ALUControlE = ctrl_e_s.alu_control;
    assign ALUSrcE     = ctrl_e_s.alu_src;
    assign sel_adderE  = ctrl_e_s.sel_adder;
    assign Rs1E        = rs1_e_s;
    assign Rs2E        = rs2_e_s;
    assign RdE         = rd_e_s;
    assign ResultSrcM  = res_m_s;
    assign MemWriteM   = memw_m_s;
    assign RegWriteM   = regw_m_s;
    assign RdM         = rd_m_s;
    assign ResultSrcW  = res_w_s;
    assign RegWriteW   = regw_w_s;
    assign RdW         = rd_w_s;
    assign PCSrcE      = pcsrc_s;
    assign ForwardAE   = fwd_a_s;
    assign ForwardBE   = fwd_b_s;
    assign StallF      = stall_s;
    assign StallD      = stall_s;
    assign FlushD      = pcsrc_s;
    assign FlushE      = flush_e_s;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb_ctrl_pipe_hazard: directed vector table, random stream against an
// instruction-level pipeline model, mid-stream reset and counter saturation
// (second instance with 4-bit counters).
module tb_ctrl_pipe_hazard;

    typedef struct packed {
        logic [1:0] res;
        logic [2:0] aluc;
        logic       memw;
        logic       alus;
        logic       regw;
        logic       br;
        logic       jmp;
        logic       sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } instr_t;

    typedef struct packed {
        logic [1:0]  res_e;
        logic [1:0]  res_m;
        logic [1:0]  res_w;
        logic [2:0]  aluc_e;
        logic        alus_e;
        logic        sel_e;
        logic        memw_m;
        logic        regw_m;
        logic        regw_w;
        logic [4:0]  rs1_e;
        logic [4:0]  rs2_e;
        logic [4:0]  rd_e;
        logic [4:0]  rd_m;
        logic [4:0]  rd_w;
        logic        pcsrc;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        stallf;
        logic        stalld;
        logic        flushd;
        logic        flushe;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } out_t;

    typedef struct {
        instr_t     d;
        bit         bc;
        bit         st;
        bit         fe;
        bit         pc;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    logic   clk;
    logic   rst;
    instr_t din;
    logic   bc;
    int     n_tests;
    int     n_fail;
    int     cyc;

    // DUT A (32-bit counters) outputs
    logic [1:0] a_res_e, a_res_m, a_res_w, a_fa, a_fb;
    logic [2:0] a_aluc;
    logic a_alus, a_sel, a_memw_m, a_regw_m, a_regw_w, a_pc, a_sf, a_sd, a_fd, a_fe;
    logic [4:0] a_rs1, a_rs2, a_rde, a_rdm, a_rdw;
    logic [31:0] a_scnt, a_fcnt;
    // DUT B (4-bit counters) outputs
    logic [1:0] b_res_e, b_res_m, b_res_w, b_fa, b_fb;
    logic [2:0] b_aluc;
    logic b_alus, b_sel, b_memw_m, b_regw_m, b_regw_w, b_pc, b_sf, b_sd, b_fd, b_fe;
    logic [4:0] b_rs1, b_rs2, b_rde, b_rdm, b_rdw;
    logic [3:0] b_scnt, b_fcnt;

    out_t o1, o4;

    ctrl_pipe_hazard #(.REG_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .ResultSrcD(din.res), .ALUControlD(din.aluc), .MemWriteD(din.memw),
        .ALUSrcD(din.alus), .RegWriteD(din.regw), .BranchD(din.br), .JumpD(din.jmp),
        .sel_adder(din.sel), .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
        .BranchCondE(bc),
        .ResultSrcE(a_res_e), .ResultSrcM(a_res_m), .ResultSrcW(a_res_w),
        .ALUControlE(a_aluc), .ALUSrcE(a_alus), .sel_adderE(a_sel),
        .MemWriteM(a_memw_m), .RegWriteM(a_regw_m), .RegWriteW(a_regw_w),
        .Rs1E(a_rs1), .Rs2E(a_rs2), .RdE(a_rde), .RdM(a_rdm), .RdW(a_rdw),
        .PCSrcE(a_pc), .ForwardAE(a_fa), .ForwardBE(a_fb),
        .StallF(a_sf), .StallD(a_sd), .FlushD(a_fd), .FlushE(a_fe),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    ctrl_pipe_hazard #(.REG_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .ResultSrcD(din.res), .ALUControlD(din.aluc), .MemWriteD(din.memw),
        .ALUSrcD(din.alus), .RegWriteD(din.regw), .BranchD(din.br), .JumpD(din.jmp),
        .sel_adder(din.sel), .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
        .BranchCondE(bc),
        .ResultSrcE(b_res_e), .ResultSrcM(b_res_m), .ResultSrcW(b_res_w),
        .ALUControlE(b_aluc), .ALUSrcE(b_alus), .sel_adderE(b_sel),
        .MemWriteM(b_memw_m), .RegWriteM(b_regw_m), .RegWriteW(b_regw_w),
        .Rs1E(b_rs1), .Rs2E(b_rs2), .RdE(b_rde), .RdM(b_rdm), .RdW(b_rdw),
        .PCSrcE(b_pc), .ForwardAE(b_fa), .ForwardBE(b_fb),
        .StallF(b_sf), .StallD(b_sd), .FlushD(b_fd), .FlushE(b_fe),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    assign o1 = {a_res_e, a_res_m, a_res_w, a_aluc, a_alus, a_sel, a_memw_m, a_regw_m, a_regw_w,
                 a_rs1, a_rs2, a_rde, a_rdm, a_rdw, a_pc, a_fa, a_fb, a_sf, a_sd, a_fd, a_fe,
                 a_scnt, a_fcnt};
    assign o4 = {b_res_e, b_res_m, b_res_w, b_aluc, b_alus, b_sel, b_memw_m, b_regw_m, b_regw_w,
                 b_rs1, b_rs2, b_rde, b_rdm, b_rdw, b_pc, b_fa, b_fb, b_sf, b_sd, b_fd, b_fe,
                 28'd0, b_scnt, 28'd0, b_fcnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: instructions sitting in E, M, W ----------------
    instr_t      in_e, in_m, in_w;
    logic [31:0] m_scnt, m_fcnt;
    int          m_scnt4, m_fcnt4;
    bit          m_stall, m_flushe;

    function automatic bit reads(input logic [4:0] rd, input instr_t d);
        return (rd != 5'd0) && (rd == d.rs1 || rd == d.rs2);
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
`ifdef CTRL_FORWARD_EN
        if (rs != 5'd0 && in_m.regw && in_m.rd == rs) return 2'b10;
        if (rs != 5'd0 && in_w.regw && in_w.rd == rs) return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic model_eval(output out_t e1, output out_t e4);
        bit hz, redir;
        hz = (in_e.res == 2'b01) && reads(in_e.rd, din);
`ifndef CTRL_FORWARD_EN
        hz = hz || (in_e.regw && reads(in_e.rd, din)) || (in_m.regw && reads(in_m.rd, din));
`endif
        redir = in_e.jmp || (in_e.br && bc);
        m_stall  = hz && !redir;
        m_flushe = hz || redir;
        e1 = '0;
        e1.res_e  = in_e.res;  e1.aluc_e = in_e.aluc; e1.alus_e = in_e.alus; e1.sel_e = in_e.sel;
        e1.rs1_e  = in_e.rs1;  e1.rs2_e  = in_e.rs2;  e1.rd_e   = in_e.rd;
        e1.res_m  = in_m.res;  e1.memw_m = in_m.memw; e1.regw_m = in_m.regw; e1.rd_m = in_m.rd;
        e1.res_w  = in_w.res;  e1.regw_w = in_w.regw; e1.rd_w   = in_w.rd;
        e1.pcsrc  = redir;     e1.flushd = redir;     e1.flushe = m_flushe;
        e1.stallf = m_stall;   e1.stalld = m_stall;
        e1.fa     = fwd_of(in_e.rs1);
        e1.fb     = fwd_of(in_e.rs2);
        e1.scnt   = m_scnt;    e1.fcnt   = m_fcnt;
        e4 = e1;
        e4.scnt = 32'(m_scnt4);
        e4.fcnt = 32'(m_fcnt4);
    endtask

    task automatic model_clock();
        if (rst) begin
            in_e = '0; in_m = '0; in_w = '0;
            m_scnt = 32'd0; m_fcnt = 32'd0; m_scnt4 = 0; m_fcnt4 = 0;
        end else begin
            if (m_stall) begin
                if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
                if (m_scnt4 < 15) m_scnt4++;
            end
            if (m_flushe) begin
                if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 32'd1;
                if (m_fcnt4 < 15) m_fcnt4++;
            end
            in_w = in_m;
            in_m = in_e;
            in_e = m_flushe ? instr_t'('0) : din;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_out(input string t, input out_t a, input out_t e);
        chk({t, ".ResultSrcE"}, 32'(a.res_e), 32'(e.res_e));
        chk({t, ".ResultSrcM"}, 32'(a.res_m), 32'(e.res_m));
        chk({t, ".ResultSrcW"}, 32'(a.res_w), 32'(e.res_w));
        chk({t, ".ALUControlE"}, 32'(a.aluc_e), 32'(e.aluc_e));
        chk({t, ".ALUSrcE"}, 32'(a.alus_e), 32'(e.alus_e));
        chk({t, ".sel_adderE"}, 32'(a.sel_e), 32'(e.sel_e));
        chk({t, ".MemWriteM"}, 32'(a.memw_m), 32'(e.memw_m));
        chk({t, ".RegWriteM"}, 32'(a.regw_m), 32'(e.regw_m));
        chk({t, ".RegWriteW"}, 32'(a.regw_w), 32'(e.regw_w));
        chk({t, ".Rs1E"}, 32'(a.rs1_e), 32'(e.rs1_e));
        chk({t, ".Rs2E"}, 32'(a.rs2_e), 32'(e.rs2_e));
        chk({t, ".RdE"}, 32'(a.rd_e), 32'(e.rd_e));
        chk({t, ".RdM"}, 32'(a.rd_m), 32'(e.rd_m));
        chk({t, ".RdW"}, 32'(a.rd_w), 32'(e.rd_w));
        chk({t, ".PCSrcE"}, 32'(a.pcsrc), 32'(e.pcsrc));
        chk({t, ".ForwardAE"}, 32'(a.fa), 32'(e.fa));
        chk({t, ".ForwardBE"}, 32'(a.fb), 32'(e.fb));
        chk({t, ".StallF"}, 32'(a.stallf), 32'(e.stallf));
        chk({t, ".StallD"}, 32'(a.stalld), 32'(e.stalld));
        chk({t, ".FlushD"}, 32'(a.flushd), 32'(e.flushd));
        chk({t, ".FlushE"}, 32'(a.flushe), 32'(e.flushe));
        chk({t, ".stall_cnt"}, a.scnt, e.scnt);
        chk({t, ".flush_cnt"}, a.fcnt, e.fcnt);
    endtask

    // One clock: inputs already driven; compare at negedge, advance model at posedge
    task automatic step(input bit has_vec, input vec_t v);
        out_t e1, e4;
        model_eval(e1, e4);
        @(negedge clk);
        check_out("cnt32", o1, e1);
        check_out("cnt4", o4, e4);
        if (has_vec) begin
            chk("vec.StallF", 32'(a_sf), 32'(v.st));
            chk("vec.StallD", 32'(a_sd), 32'(v.st));
            chk("vec.FlushE", 32'(a_fe), 32'(v.fe));
            chk("vec.FlushD", 32'(a_fd), 32'(v.pc));
            chk("vec.PCSrcE", 32'(a_pc), 32'(v.pc));
            chk("vec.ForwardAE", 32'(a_fa), 32'(v.fa));
            chk("vec.ForwardBE", 32'(a_fb), 32'(v.fb));
        end
        @(posedge clk);
        model_clock();
        cyc++;
        #1;
    endtask

    function automatic instr_t mk(input logic [1:0] res, input logic regw, input logic br,
                                  input logic jmp, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd);
        instr_t r;
        r.res = res; r.regw = regw; r.br = br; r.jmp = jmp;
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.aluc = rd[2:0]; r.alus = rs2[0]; r.sel = rs1[0]; r.memw = ~regw;
        return r;
    endfunction

    function automatic vec_t row(input instr_t d, input bit b, input bit st, input bit fe,
                                 input bit pc, input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.d = d; v.bc = b; v.st = st; v.fe = fe; v.pc = pc; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t r;
        r.res  = 2'($urandom_range(0, 3));
        r.aluc = 3'($urandom_range(0, 7));
        r.memw = 1'($urandom_range(0, 1));
        r.alus = 1'($urandom_range(0, 1));
        r.regw = 1'($urandom_range(0, 1));
        r.br   = ($urandom_range(0, 5) == 0);
        r.jmp  = ($urandom_range(0, 9) == 0);
        r.sel  = 1'($urandom_range(0, 1));
        r.rs1  = 5'($urandom_range(0, 3));
        r.rs2  = 5'($urandom_range(0, 3));
        r.rd   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
        return r;
    endfunction

    vec_t tbl[$];
    vec_t nov;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        nov = row('0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        rst = 1'b1; din = '0; bc = 1'b0;
        in_e = '0; in_m = '0; in_w = '0;
        m_scnt = 32'd0; m_fcnt = 32'd0; m_scnt4 = 0; m_fcnt4 = 0;
        @(posedge clk);
        #1;
        step(1'b0, nov);
        rst = 1'b0;

        // Directed table: forwarding, load-use, branch/jump, stall+redirect conflict
`ifdef CTRL_FORWARD_EN
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd1,5'd2,5'd5),  0, 0,0,0, 2'b00,2'b00)); // add x5
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd5,5'd1,5'd6),  0, 0,0,0, 2'b00,2'b00)); // sub x6,x5,x1
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd3,5'd5,5'd7),  0, 0,0,0, 2'b10,2'b00)); // sub in E: A from M
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd5,5'd5,5'd0),  0, 0,0,0, 2'b00,2'b01)); // or in E: B from W
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd0,5'd0,5'd8),  0, 0,0,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd1,1,0,0, 5'd8,5'd0,5'd9),  0, 0,0,0, 2'b00,2'b00)); // x0 writer in M
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd1,5'd9,5'd10), 0, 1,1,0, 2'b10,2'b00)); // load-use
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd1,5'd9,5'd10), 0, 0,0,0, 2'b00,2'b00)); // bubble in E
        tbl.push_back(row(mk(2'd0,0,1,0, 5'd1,5'd2,5'd0),  0, 0,0,0, 2'b00,2'b01));
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd2,5'd3,5'd11), 1, 0,1,1, 2'b00,2'b00)); // taken beq
        tbl.push_back(row(mk(2'd2,1,0,1, 5'd0,5'd0,5'd0),  0, 0,0,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd1,1,0,0, 5'd1,5'd0,5'd12), 0, 0,1,1, 2'b00,2'b00)); // jal in E
        tbl.push_back(row(mk(2'd1,1,0,0, 5'd1,5'd0,5'd12), 0, 0,0,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd1,1,0,1, 5'd0,5'd0,5'd5),  0, 0,0,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd5,5'd0,5'd6),  0, 0,1,1, 2'b00,2'b00)); // load-use + redirect
`else
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd1,5'd2,5'd5),  0, 0,0,0, 2'b00,2'b00)); // add x5
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd5,5'd5,5'd6),  0, 1,1,0, 2'b00,2'b00)); // RAW on E
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd5,5'd5,5'd6),  0, 1,1,0, 2'b00,2'b00)); // RAW on M
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd5,5'd5,5'd6),  0, 0,0,0, 2'b00,2'b00)); // writer in W
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd0,5'd0,5'd7),  0, 0,0,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd1,5'd1,5'd0),  0, 0,0,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd0,5'd0,5'd8),  0, 0,0,0, 2'b00,2'b00)); // x0 never stalls
        tbl.push_back(row(mk(2'd1,1,0,0, 5'd1,5'd0,5'd9),  0, 0,0,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd9,5'd9,5'd10), 0, 1,1,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd9,5'd9,5'd10), 0, 1,1,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd9,5'd9,5'd10), 0, 0,0,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd0,0,1,0, 5'd1,5'd2,5'd0),  0, 0,0,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd3,5'd4,5'd11), 1, 0,1,1, 2'b00,2'b00)); // taken beq
        tbl.push_back(row(mk(2'd2,1,0,1, 5'd0,5'd0,5'd0),  0, 0,0,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd0,5'd0,5'd12), 0, 0,1,1, 2'b00,2'b00)); // jal in E
        tbl.push_back(row(mk(2'd1,1,0,1, 5'd0,5'd0,5'd5),  0, 0,0,0, 2'b00,2'b00));
        tbl.push_back(row(mk(2'd0,1,0,0, 5'd5,5'd0,5'd6),  0, 0,1,1, 2'b00,2'b00)); // stall + redirect
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            din = tbl[i].d;
            bc  = tbl[i].bc;
            step(1'b1, tbl[i]);
        end

        // Random stream against the model
        for (int i = 0; i < 400; i++) begin
            din = rnd_instr();
            bc  = 1'($urandom_range(0, 1));
            step(1'b0, nov);
        end

        // Mid-stream reset held for two cycles
        rst = 1'b1;
        din = rnd_instr();
        step(1'b0, nov);
        din = rnd_instr();
        step(1'b0, nov);
        rst = 1'b0;
        din = '0;
        bc  = 1'b1;
        @(negedge clk);
        chk("rst.PCSrcE", 32'(a_pc), 32'd0);
        chk("rst.stall_cnt", a_scnt, 32'd0);
        chk("rst.flush_cnt", a_fcnt, 32'd0);
        chk("rst.RdE", 32'(a_rde), 32'd0);
        chk("rst.RegWriteM", 32'(a_regw_m), 32'd0);
        chk("rst.RegWriteW", 32'(a_regw_w), 32'd0);
        chk("rst.FlushE", 32'(a_fe), 32'd0);
        @(posedge clk);
        model_clock();
        #1;

        // Repeated load-use on x1 to drive the 4-bit stall counter into saturation
        din = mk(2'd1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 5'd1);
        bc  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, nov);
        end
        @(negedge clk);
        chk("sat.stall_cnt4", 32'(b_scnt), 32'd15);
        chk("sat.stall_cnt32_ge20", 32'(a_scnt >= 32'd20), 32'd1);
        @(posedge clk);
        model_clock();
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
